// File: rtl/reg_file_mp_pkg.sv
// CPU-wide register-file defaults shared by the integer pipeline.
package reg_file_mp_pkg;

    localparam int CPU_DATA_W   = 32;
    localparam int CPU_ADDR_W   = 5;
    localparam int CPU_LINK_REG = 31;
    localparam int CPU_SP_REG   = 29;
    localparam int CPU_SP_RST   = 128;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear.
module reg_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_a_en_i,
    input  logic [ADDR_W-1:0] clr_a_addr_i,
    input  logic              clr_b_en_i,
    input  logic [ADDR_W-1:0] clr_b_addr_i,
    output logic [DEPTH-1:0]  busy_o
);

    // Bit 0 is only ever written by reset, so it stays constant 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= '0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (set_en_i && set_addr_i == ADDR_W'(a))
                    busy_o[a] <= 1'b1;
                else if ((clr_a_en_i && clr_a_addr_i == ADDR_W'(a)) ||
                         (clr_b_en_i && clr_b_addr_i == ADDR_W'(a)))
                    busy_o[a] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with link-register write port,
// optional write-to-read bypass and a pending-write scoreboard.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = CPU_LINK_REG,
    parameter int SP_REG   = CPU_SP_REG,
    parameter int SP_RST   = CPU_SP_RST
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     link_en_i,
    input  logic [DATA_W-1:0]        link_data_i,
    input  logic                     busy_set_i,
    input  logic [ADDR_W-1:0]        busy_addr_i,
    output logic [2**ADDR_W-1:0]     busy_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [DEPTH];

    // NOTE: the array is reset as flops (async), since the stack pointer
    // needs a nonzero value the instant reset asserts; it cannot map to RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int a = 0; a < DEPTH; a++)
                regs[a] <= (a == SP_REG) ? DATA_W'(SP_RST) : '0;
        end else begin
            // Main write is tested first so it wins a collision on LINK_REG.
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en_i && wr_addr_i == ADDR_W'(a))
                    regs[a] <= wr_data_i;
                else if (link_en_i && a == LINK_REG)
                    regs[a] <= link_data_i;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_en_i     (busy_set_i),
        .set_addr_i   (busy_addr_i),
        .clr_a_en_i   (wr_en_i),
        .clr_a_addr_i (wr_addr_i),
        .clr_b_en_i   (link_en_i),
        .clr_b_addr_i (LINK_ADDR),
        .busy_o       (busy_o)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        // Forwarding mirrors the write priority: main write, then link.
        always_comb begin
            data = regs[addr];
            if (addr == '0)
                data = '0;
            else if (BYPASS != 0 && wr_en_i && wr_addr_i == addr)
                data = wr_data_i;
            else if (BYPASS != 0 && link_en_i && addr == LINK_ADDR)
                data = link_data_i;
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        assign rd_busy_o[k]                  = busy_o[addr];
    end

endmodule
